arb_vrp_wrr: RTL and testbench
==============================

// Module: arb_vrp_wrr
// PURPOSE
//  N:1 valid/ready arbiter with payload mux. Successor to the single-beat arbiter:
//  - adds packet lock on a last flag, weighted round-robin and grant hold under stall.
//  - the optional output stage is a backpressure-correct register slice.
//  Sits in front of shared buses and ports. Output carries the winning channel id.
// PARAMETERS
//  MODE       1   0: fixed priority (index 0 highest), 1: round robin, 2: weighted RR
//  OUT_REG    1   0: combinational pass-through, 1: registered output stage, full throughput
//  WIDTH      4   number of input channels, >=2
//  PLD_WIDTH  32  payload width
//  WGT_WIDTH  4   weight field width (MODE 2 only)
//  IDW        $clog2(WIDTH)  width of id_m
// PORTS
//  clk       in   1                    clock
//  rst_n     in   1                    asynchronous active-low reset
//  v_vld_s   in   WIDTH                per-channel valid
//  v_rdy_s   out  WIDTH                per-channel ready (one-hot or zero)
//  v_pld_s   in   PLD_WIDTH x WIDTH    per-channel payload (unpacked array)
//  v_last_s  in   WIDTH                per-channel last-beat-of-packet flag
//  v_wgt_s   in   WGT_WIDTH x WIDTH    per-channel packet weight, quasi-static
//  vld_m     out  1                    master valid
//  rdy_m     in   1                    master ready
//  pld_m     out  PLD_WIDTH            master payload
//  last_m    out  1                    master last
//  id_m      out  IDW                  index of the channel that sourced the beat
// BEHAVIOUR
//  - Reset: vld_m=0, pld_m=0, last_m=0, id_m=0.
//    Internal state cleared: ptr=0, pkt_cnt=0, locked=0, hold=0.
//  - Accept on input i: v_vld_s[i] & v_rdy_s[i]. At most one per cycle.
//  - Sources hold vld and pld until accepted.
//  - Grant is one-hot and is chosen in this order:
//    - locked: the grant is the lock owner only.
//    - else hold (OUT_REG=0 with vld_m & ~rdy_m): the grant is the previous cycle's grant.
//    - else the grant is computed:
//      - MODE 0: lowest valid index.
//      - MODE 1/2: first valid index at or after ptr, cyclic.
//  - Lock:
//    - Set on accepting a beat with last=0; the owner is that channel.
//    - Cleared on accepting the owner's beat with last=1.
//    - A single beat with last=1 never locks.
//    - While locked, other channels get rdy=0 even if the owner is idle.
//  - Packet completion is the accept of a last=1 beat from channel g.
//    - MODE 1: ptr <= (g+1)%WIDTH.
//    - MODE 2: ew = (v_wgt_s[g]==0) ? 1 : v_wgt_s[g].
//      - If pkt_cnt+1 < ew: ptr <= g and pkt_cnt++.
//      - Else: ptr <= (g+1)%WIDTH and pkt_cnt <= 0.
//    - MODE 2, winner g != ptr: pkt_cnt <= 0 first, then the rule above applies.
//    - ptr wraps from WIDTH-1 to 0.
//  - OUT_REG=0:
//    - vld_m = |(v_vld_s & grant); pld_m, last_m and id_m come from the granted channel.
//    - v_rdy_s = grant & {WIDTH{rdy_m}}. Latency 0.
//  - OUT_REG=1:
//    - Output register slice; slice_en = ~vld_m | rdy_m.
//    - v_rdy_s = grant & {WIDTH{slice_en}}.
//    - On accept: the register loads pld, last and id, and vld_m <= 1.
//    - Else if rdy_m: vld_m <= 0.
//    - Latency 1. Back-to-back beats flow at 1 beat/cycle.
//    - pld_m, last_m and id_m are stable while vld_m & ~rdy_m.
//  - No valid inputs: grant=0 and v_rdy_s=0. ptr and pkt_cnt are unchanged.
//  - WIDTH not a power of two: ptr still wraps at WIDTH. IDW=1 when WIDTH=2.
//  - Weight changes take effect at the next packet completion only.
//  - Reset mid-packet: lock dropped and the output beat discarded. The source restarts the packet.
// STRUCTURE
//  - Package arb_vrp_pkg:
//    - mode localparams ARB_FP=0, ARB_RR=1, ARB_WRR=2.
//    - function rr_pick(vld, ptr), which returns the one-hot first set bit at or after ptr.
//    - function onehot2idx.
//  - Sub-module arb_wrr_core: grant logic plus ptr, pkt_cnt, lock and hold state.
//    - Inputs: v_vld, v_last, v_wgt, accept, out_stall.
//    - Outputs: v_grant and grant_idx.
//  - Payload mux: existing real_mux_onehot instance. Top level: the output slice only.
// TESTING
//  1 MODE1 WIDTH4: all 4 valid, single-beat, rdy_m=1.
//    -> ids 0,1,2,3,0 on consecutive beats. OUT_REG=1: first vld_m one cycle later.
//  2 MODE1: ch1 sends a 3-beat packet (last on the 3rd) while ch0 and ch2 are valid.
//    -> ids 1,1,1 contiguous, then 2. ch0 rdy=0 during the packet.
//  3 MODE2: v_wgt={1,1,1,3} (ch3=3), all channels valid, single-beat.
//    -> ids 0,1,2,3,3,3,0,1. Weight 0 on ch1 acts as 1.
//  4 OUT_REG=1: stream from ch2 with rdy_m toggling 1,0,0,1.
//    -> pld_m and id_m held during the stall, no beat lost or duplicated, v_rdy_s[2]=0 during the stall.
//  5 OUT_REG=0: ch3 valid, rdy_m=0, then ch0 rises.
//    -> grant stays on ch3 until accepted, then ch0.
//  6 Assert rst_n=0 on the 2nd beat of a locked ch1 packet.
//    -> vld_m=0 immediately. After release, ch0 wins (ptr=0, unlocked).
//  - Scoreboard: per-channel in-order delivery; checks id_m and last_m on every beat.

Source files
------------

// File: rtl/arb_vrp_pkg.sv
// Shared arbitration mode codes and grant helper functions.
package arb_vrp_pkg;

    localparam int ARB_FP  = 0;
    localparam int ARB_RR  = 1;
    localparam int ARB_WRR = 2;

    // Helpers work on a fixed-width vector; callers zero-extend their request vector.
    localparam int MAXW = 32;

    // One-hot of the first set bit at or after ptr, searching cyclically.
    // Bits above the caller's width are zero, so the wrap lands at the caller's width.
    function automatic logic [MAXW-1:0] rr_pick(input logic [MAXW-1:0] vld,
                                                input logic [4:0]      ptr);
        logic [MAXW-1:0] res;
        logic [4:0]      j;
        res = '0;
        // Walk from farthest to nearest so the nearest set bit is the one kept.
        for (int k = MAXW - 1; k >= 0; k--) begin
            j = ptr + 5'(k);
            if (vld[j]) res = MAXW'(1) << j;
        end
        return res;
    endfunction

    function automatic logic [4:0] onehot2idx(input logic [MAXW-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int k = 0; k < MAXW; k++)
            if (oh[k]) idx = idx | 5'(k);
        return idx;
    endfunction

endpackage

// File: rtl/arb_wrr_core.sv
// Grant selection plus round-robin pointer, weight counter, packet lock and stall hold.
module arb_wrr_core
    import arb_vrp_pkg::*;
#(
    parameter int MODE      = ARB_RR,
    parameter int WIDTH     = 4,
    parameter int WGT_WIDTH = 4,
    parameter int IDW       = $clog2(WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WIDTH-1:0]                v_vld,
    input  logic [WIDTH-1:0]                v_last,
    input  logic [WIDTH-1:0][WGT_WIDTH-1:0] v_wgt,
    input  logic                            accept,
    input  logic                            out_stall,
    output logic [WIDTH-1:0]                v_grant,
    output logic [IDW-1:0]                  grant_idx
);

    logic [IDW-1:0]       ptr, owner, g_nxt;
    logic [WGT_WIDTH-1:0] pkt_cnt, cnt_base;
    logic [WGT_WIDTH:0]   ew, cnt_inc;
    logic                 locked, hold;
    logic [WIDTH-1:0]     prev_grant, owner_oh;
    logic [MAXW-1:0]      pick;

    // Grant priority: lock owner, then held grant under output stall, then fresh pick.
    always_comb begin
        pick     = rr_pick(MAXW'(v_vld), (MODE == ARB_FP) ? 5'd0 : 5'(ptr));
        owner_oh = WIDTH'(1) << owner;
        if (locked)    v_grant = v_vld & owner_oh;
        else if (hold) v_grant = v_vld & prev_grant;
        else           v_grant = pick[WIDTH-1:0];
        grant_idx = IDW'(onehot2idx(MAXW'(v_grant)));
    end

    // Next pointer and weighted-packet bookkeeping for the current winner.
    always_comb begin
        g_nxt    = (grant_idx == IDW'(WIDTH - 1)) ? '0 : grant_idx + 1'b1;
        ew       = (v_wgt[grant_idx] == '0) ? (WGT_WIDTH+1)'(1) : {1'b0, v_wgt[grant_idx]};
        // A winner other than ptr starts a fresh weight count.
        cnt_base = (grant_idx != ptr) ? '0 : pkt_cnt;
        cnt_inc  = {1'b0, cnt_base} + 1'b1;
    end

    // Lock, hold and pointer state; ptr only moves on packet completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            pkt_cnt    <= '0;
            locked     <= 1'b0;
            owner      <= '0;
            hold       <= 1'b0;
            prev_grant <= '0;
        end else begin
            hold       <= out_stall;
            prev_grant <= v_grant;
            if (accept) begin
                if (!v_last[grant_idx]) begin
                    locked <= 1'b1;
                    owner  <= grant_idx;
                end else begin
                    locked <= 1'b0;
                    if (MODE == ARB_RR) begin
                        ptr <= g_nxt;
                    end else if (MODE == ARB_WRR) begin
                        if (cnt_inc < ew) begin
                            ptr     <= grant_idx;
                            pkt_cnt <= cnt_inc[WGT_WIDTH-1:0];
                        end else begin
                            ptr     <= g_nxt;
                            pkt_cnt <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/real_mux_onehot.sv
// AND-OR multiplexer driven by a one-hot (or all-zero) select.
module real_mux_onehot #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N-1:0] sel,
    input  logic [W-1:0] din [N],
    output logic [W-1:0] dout
);

    // OR of every input gated by its select bit; zero select gives zero.
    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++)
            dout = dout | (din[i] & {W{sel[i]}});
    end

endmodule

// File: rtl/arb_vrp_wrr.sv
// N:1 valid/ready arbiter with packet lock, weighted RR and optional output slice.
module arb_vrp_wrr
    import arb_vrp_pkg::*;
#(
    parameter int MODE      = 1,
    parameter int OUT_REG   = 1,
    parameter int WIDTH     = 4,
    parameter int PLD_WIDTH = 32,
    parameter int WGT_WIDTH = 4,
    parameter int IDW       = $clog2(WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WIDTH-1:0]                v_vld_s,
    output logic [WIDTH-1:0]                v_rdy_s,
    input  logic [PLD_WIDTH-1:0]            v_pld_s [WIDTH],
    input  logic [WIDTH-1:0]                v_last_s,
    input  logic [WIDTH-1:0][WGT_WIDTH-1:0] v_wgt_s,
    output logic                            vld_m,
    input  logic                            rdy_m,
    output logic [PLD_WIDTH-1:0]            pld_m,
    output logic                            last_m,
    output logic [IDW-1:0]                  id_m
);

    logic [WIDTH-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             accept, out_stall;
    logic [PLD_WIDTH:0] mux_in [WIDTH];
    logic [PLD_WIDTH:0] mux_out;

    assign accept = |(v_vld_s & v_rdy_s);

    // Last flag travels with the payload through the mux.
    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            mux_in[i] = {v_last_s[i], v_pld_s[i]};
    end

    arb_wrr_core #(
        .MODE(MODE), .WIDTH(WIDTH), .WGT_WIDTH(WGT_WIDTH), .IDW(IDW)
    ) u_core (
        .clk(clk), .rst_n(rst_n), .v_vld(v_vld_s), .v_last(v_last_s), .v_wgt(v_wgt_s),
        .accept(accept), .out_stall(out_stall), .v_grant(grant), .grant_idx(grant_idx)
    );

    real_mux_onehot #(.N(WIDTH), .W(PLD_WIDTH + 1)) u_mux (
        .sel(grant), .din(mux_in), .dout(mux_out)
    );

    generate
        if (OUT_REG == 0) begin : g_comb
            // Pass-through; outputs forced quiet while reset is held.
            assign vld_m     = rst_n & |(v_vld_s & grant);
            assign v_rdy_s   = grant & {WIDTH{rst_n & rdy_m}};
            assign pld_m     = rst_n ? mux_out[PLD_WIDTH-1:0] : '0;
            assign last_m    = rst_n & mux_out[PLD_WIDTH];
            assign id_m      = rst_n ? grant_idx : '0;
            assign out_stall = vld_m & ~rdy_m;
        end else begin : g_reg
            logic slice_en;
            assign slice_en  = ~vld_m | rdy_m;
            assign v_rdy_s   = grant & {WIDTH{slice_en}};
            assign out_stall = 1'b0;

            // Register slice: load on accept, drain when the sink takes the beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_m  <= 1'b0;
                    pld_m  <= '0;
                    last_m <= 1'b0;
                    id_m   <= '0;
                end else if (accept) begin
                    vld_m  <= 1'b1;
                    pld_m  <= mux_out[PLD_WIDTH-1:0];
                    last_m <= mux_out[PLD_WIDTH];
                    id_m   <= grant_idx;
                end else if (rdy_m) begin
                    vld_m  <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_arb_vrp_wrr.sv
// Scoreboard bench: instance A is weighted RR with output slice, instance C is RR pass-through.
module tb_arb_vrp_wrr;

    localparam int W  = 4;
    localparam int PW = 32;
    localparam int GW = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [PW-1:0] pld;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0][W-1:0] vld, last;
    logic [1:0]        mr;
    logic [PW-1:0]     pld_a [W];
    logic [PW-1:0]     pld_c [W];
    logic [W-1:0][GW-1:0] wgt_a, wgt_c;

    logic [W-1:0]  rdy_a, rdy_c;
    logic          mv_a, mv_c, ml_a, ml_c;
    logic [PW-1:0] mp_a, mp_c;
    logic [IW-1:0] mi_a, mi_c;

    beat_t         srcq [2][W][$];
    beat_t         expq [2][W][$];
    logic [IW-1:0] idq  [2][$];

    int nchk = 0;
    int nerr = 0;
    int seq  = 0;

    int t1a [5] = '{0, 1, 2, 3, 0};
    int t1c [4] = '{0, 1, 2, 3};
    int t2a [5] = '{1, 1, 1, 2, 0};
    int t3a [8] = '{1, 2, 3, 3, 3, 0, 1, 2};
    int t6a [4] = '{0, 1, 1, 1};

    always #5 clk = ~clk;

    arb_vrp_wrr #(.MODE(2), .OUT_REG(1), .WIDTH(W), .PLD_WIDTH(PW), .WGT_WIDTH(GW)) u_a (
        .clk(clk), .rst_n(rst_n), .v_vld_s(vld[0]), .v_rdy_s(rdy_a), .v_pld_s(pld_a),
        .v_last_s(last[0]), .v_wgt_s(wgt_a), .vld_m(mv_a), .rdy_m(mr[0]), .pld_m(mp_a),
        .last_m(ml_a), .id_m(mi_a)
    );

    arb_vrp_wrr #(.MODE(1), .OUT_REG(0), .WIDTH(W), .PLD_WIDTH(PW), .WGT_WIDTH(GW)) u_c (
        .clk(clk), .rst_n(rst_n), .v_vld_s(vld[1]), .v_rdy_s(rdy_c), .v_pld_s(pld_c),
        .v_last_s(last[1]), .v_wgt_s(wgt_c), .vld_m(mv_c), .rdy_m(mr[1]), .pld_m(mp_c),
        .last_m(ml_c), .id_m(mi_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input int s, output logic [W-1:0] r, output logic v,
                        output logic [PW-1:0] p, output logic l, output logic [IW-1:0] id);
        if (s == 0) begin r = rdy_a; v = mv_a; p = mp_a; l = ml_a; id = mi_a; end
        else        begin r = rdy_c; v = mv_c; p = mp_c; l = ml_c; id = mi_c; end
    endtask

    // Present the head of each source queue; sources hold until accepted.
    task automatic drive();
        beat_t b;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < W; i++) begin
                vld[s][i] = (srcq[s][i].size() > 0);
                b = vld[s][i] ? srcq[s][i][0] : '0;
                last[s][i] = b.last;
                if (s == 0) pld_a[i] = b.pld;
                else        pld_c[i] = b.pld;
            end
    endtask

    task automatic send(input int s, input int ch, input logic lst);
        beat_t b;
        b.pld  = {8'(s), 8'(ch), 16'(seq)};
        b.last = lst;
        seq++;
        srcq[s][ch].push_back(b);
        expq[s][ch].push_back(b);
    endtask

    task automatic out_beat(input int s, input logic [PW-1:0] p, input logic l,
                            input logic [IW-1:0] id);
        beat_t e;
        if (idq[s].size() == 0) chk("beat_unexp", idq[s].size(), 1);
        else                    chk("beat_id", id, idq[s].pop_front());
        if (expq[s][id].size() == 0) chk("beat_orphan", expq[s][id].size(), 1);
        else begin
            e = expq[s][id].pop_front();
            chk("beat_pld", p, e.pld);
            chk("beat_last", l, e.last);
        end
    endtask

    // One clock: sample at negedge, update sources after posedge, return to negedge.
    task automatic cyc();
        logic [1:0][W-1:0] acc;
        logic [W-1:0]  r;
        logic          v, l;
        logic [PW-1:0] p;
        logic [IW-1:0] id;
        for (int s = 0; s < 2; s++) begin
            peek(s, r, v, p, l, id);
            acc[s] = rst_n ? (vld[s] & r) : '0;
            if (rst_n && v && mr[s]) out_beat(s, p, l, id);
        end
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < W; i++)
                if (acc[s][i] && srcq[s][i].size() > 0) void'(srcq[s][i].pop_front());
        drive();
        @(negedge clk); #1;
    endtask

    task automatic drain(input int s);
        int n = 0;
        while (idq[s].size() != 0 && n < 60) begin
            cyc();
            n++;
        end
        chk("drain", idq[s].size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0]  r;
        logic          v, l;
        logic [PW-1:0] p, p0;
        logic [IW-1:0] id;

        rst_n = 1'b0;
        mr    = 2'b11;
        wgt_a = {4'd1, 4'd1, 4'd1, 4'd1};
        wgt_c = {4'd1, 4'd1, 4'd1, 4'd1};
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            peek(s, r, v, p, l, id);
            chk("rst_vld", v, 0);
            chk("rst_pld", p, 0);
            chk("rst_last", l, 0);
            chk("rst_id", id, 0);
        end
        rst_n = 1'b1;
        #1;

        // Plain round robin on the sliced instance; first beat out one cycle late.
        for (int k = 0; k < 5; k++) send(0, t1a[k], 1'b1);
        foreach (t1a[k]) idq[0].push_back(IW'(t1a[k]));
        drive(); #1;
        peek(0, r, v, p, l, id);
        chk("t1_lat_vld", v, 0);
        chk("t1_rdy", r, 4'b0001);
        drain(0);

        // Same on the pass-through instance: zero latency.
        for (int k = 0; k < 4; k++) send(1, t1c[k], 1'b1);
        foreach (t1c[k]) idq[1].push_back(IW'(t1c[k]));
        drive(); #1;
        peek(1, r, v, p, l, id);
        chk("t1c_vld", v, 1);
        chk("t1c_id", id, 0);
        chk("t1c_rdy", r, 4'b0001);
        drain(1);

        // ch1 packet of 3 beats; lock holds even while ch1 idles mid-packet.
        send(0, 0, 1'b1);
        send(0, 1, 1'b0);
        send(0, 2, 1'b1);
        foreach (t2a[k]) idq[0].push_back(IW'(t2a[k]));
        drive(); #1;
        peek(0, r, v, p, l, id);
        chk("t2_first", r, 4'b0010);
        cyc();
        for (int k = 0; k < 2; k++) begin
            peek(0, r, v, p, l, id);
            chk("t2_lock_idle", r, 4'b0000);
            cyc();
        end
        send(0, 1, 1'b0);
        send(0, 1, 1'b1);
        drive(); #1;
        for (int k = 0; k < 2; k++) begin
            peek(0, r, v, p, l, id);
            chk("t2_rdy0", r[0], 0);
            chk("t2_rdy1", r[1], 1);
            cyc();
        end
        drain(0);

        // Weighted: ch3 gets 3 packets per turn, weight 0 on ch1 counts as 1.
        wgt_a[1] = 4'd0;
        wgt_a[3] = 4'd3;
        send(0, 0, 1'b1);
        for (int k = 0; k < 2; k++) begin send(0, 1, 1'b1); send(0, 2, 1'b1); end
        for (int k = 0; k < 3; k++) send(0, 3, 1'b1);
        foreach (t3a[k]) idq[0].push_back(IW'(t3a[k]));
        drive(); #1;
        drain(0);

        // ch2 stream with sink stalling two cycles: output held, input blocked.
        for (int k = 0; k < 4; k++) begin send(0, 2, 1'b1); idq[0].push_back(IW'(2)); end
        p0 = expq[0][2][0].pld;
        drive(); #1;
        cyc();
        for (int k = 0; k < 2; k++) begin
            mr[0] = 1'b0; #1;
            peek(0, r, v, p, l, id);
            chk("t4_vld", v, 1);
            chk("t4_rdy2", r[2], 0);
            chk("t4_pld", p, p0);
            chk("t4_id", id, 2);
            cyc();
        end
        mr[0] = 1'b1; #1;
        drain(0);

        // Move ptr to 1 so a stale ptr or lock would favour ch1 after reset.
        send(0, 0, 1'b1);
        idq[0].push_back(IW'(0));
        drive(); #1;
        drain(0);

        // Reset during the second beat of a locked ch1 packet.
        for (int k = 0; k < 3; k++) send(0, 1, (k == 2));
        idq[0].push_back(IW'(1));
        drive(); #1;
        cyc();
        cyc();
        rst_n = 1'b0; #1;
        peek(0, r, v, p, l, id);
        chk("t6_rst_vld", v, 0);
        chk("t6_rst_id", id, 0);
        chk("t6_rst_pld", p, 0);
        srcq[0][1].delete();
        expq[0][1].delete();
        idq[0].delete();
        drive();
        @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) send(0, 1, (k == 2));
        send(0, 0, 1'b1);
        foreach (t6a[k]) idq[0].push_back(IW'(t6a[k]));
        drive(); #1;
        peek(0, r, v, p, l, id);
        chk("t6_grant", r, 4'b0001);
        drain(0);

        // Pass-through hold: ch3 stalled, ch0 arrives with ptr=0, grant must stay on ch3.
        mr[1] = 1'b0;
        send(1, 3, 1'b1);
        idq[1].push_back(IW'(3));
        idq[1].push_back(IW'(0));
        drive(); #1;
        peek(1, r, v, p, l, id);
        chk("t5_vld", v, 1);
        chk("t5_id", id, 3);
        chk("t5_rdy", r, 4'b0000);
        cyc();
        send(1, 0, 1'b1);
        drive(); #1;
        for (int k = 0; k < 2; k++) begin
            peek(1, r, v, p, l, id);
            chk("t5_hold_id", id, 3);
            chk("t5_hold_rdy", r, 4'b0000);
            cyc();
        end
        mr[1] = 1'b1; #1;
        peek(1, r, v, p, l, id);
        chk("t5_release", r, 4'b1000);
        drain(1);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
